// File: rtl/geofence_pkg.sv
// rtl/geofence_pkg.sv - shared constants, point type and playout states for the geofence feeder
package geofence_pkg;

    localparam int COORD_W = 10;
    localparam int NPTS    = 7;
    localparam int IDX_W   = $clog2(NPTS);

    // Level of reset_n that holds the block in reset
    localparam logic RST_ACTIVE = 1'b0;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    typedef enum logic {
        PLAY = 1'b0,
        WAIT = 1'b1
    } play_state_t;

    // Index of the final point of a frame
    function automatic logic [IDX_W-1:0] last_idx();
        return IDX_W'(NPTS - 1);
    endfunction

endpackage

// File: rtl/geofence_feeder_if.sv
// rtl/geofence_feeder_if.sv - point stream, engine X/Y and verdict signals of the geofence feeder
interface geofence_feeder_if #(
    parameter int ID_W = 4
);
    import geofence_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [COORD_W-1:0] in_x;
    logic [COORD_W-1:0] in_y;
    logic               in_last;
    logic [COORD_W-1:0] X;
    logic [COORD_W-1:0] Y;
    logic               fence_valid;
    logic               fence_inside;
    logic               res_valid;
    logic               res_inside;
    logic [ID_W-1:0]    res_id;
    logic               frame_err;
    logic               fence_err;

    modport master (
        output in_valid, in_x, in_y, in_last, fence_valid, fence_inside,
        input  in_ready, X, Y, res_valid, res_inside, res_id, frame_err, fence_err
    );

    modport slave (
        input  in_valid, in_x, in_y, in_last, fence_valid, fence_inside,
        output in_ready, X, Y, res_valid, res_inside, res_id, frame_err, fence_err
    );

endinterface

// File: rtl/geofence_frame_buf.sv
// rtl/geofence_frame_buf.sv - two-bank frame store with full flags, frame tags and bank pointers
module geofence_frame_buf
    import geofence_pkg::*;
#(
    parameter int ID_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  point_t           i_wr_pt,
    input  logic             i_commit,
    input  logic [ID_W-1:0]  i_commit_tag,
    input  logic             i_release,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_wr_full,
    output logic             o_rd_full,
    output point_t           o_rd_pt,
    output logic [ID_W-1:0]  o_rd_tag
);

    point_t          r_mem [2][NPTS];
    logic [1:0]      r_full;
    logic [ID_W-1:0] r_tag [2];
    logic            r_wr_bank;
    logic            r_rd_bank;

    assign o_wr_full = r_full[r_wr_bank];
    assign o_rd_full = r_full[r_rd_bank];
    assign o_rd_pt   = r_mem[r_rd_bank][i_rd_idx];
    assign o_rd_tag  = r_tag[r_rd_bank];

    // Point storage: plain data, only read back while its bank is flagged full
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_bank][i_wr_idx] <= i_wr_pt;
        end
    end

    // Bank bookkeeping: commit fills the write bank, release frees the read bank (never the same bank)
    always_ff @(posedge clk or negedge reset_n) begin
        if (reset_n == RST_ACTIVE) begin
            r_full    <= '0;
            r_tag[0]  <= '0;
            r_tag[1]  <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            if (i_commit) begin
                r_full[r_wr_bank] <= 1'b1;
                r_tag[r_wr_bank]  <= i_commit_tag;
                r_wr_bank         <= ~r_wr_bank;
            end
            if (i_release) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
        end
    end

endmodule

// File: rtl/geofence_feeder.sv
// rtl/geofence_feeder.sv - frame assembly, 7-cycle playout and verdict pairing; watchdog under GEOFENCE_FEEDER_WATCHDOG_EN
module geofence_feeder
    import geofence_pkg::*;
#(
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    geofence_feeder_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = last_idx();

    logic [IDX_W-1:0] r_wr_idx;
    logic [ID_W-1:0]  r_tag_cnt;
    logic             r_frame_err;

    play_state_t      r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_real;
    logic [ID_W-1:0]  r_cur_tag;
    logic             r_res_valid;
    logic             r_res_inside;
    logic [ID_W-1:0]  r_res_id;

    logic             w_wr_full;
    logic             w_rd_full;
    point_t           w_rd_pt;
    logic [ID_W-1:0]  w_rd_tag;
    point_t           w_wr_pt;

    logic w_accept;
    logic w_at_last;
    logic w_bad;
    logic w_wr_en;
    logic w_commit;
    logic w_at_idx0;
    logic w_real;
    logic w_release;

    assign bus.in_ready = !w_wr_full;
    assign w_accept     = bus.in_valid && !w_wr_full;
    assign w_at_last    = (r_wr_idx == LAST_IDX);
    // in_last must coincide exactly with the 7th point, otherwise the partial frame is dropped
    assign w_bad        = w_accept && (bus.in_last != w_at_last);
    assign w_wr_en      = w_accept && !w_bad;
    assign w_commit     = w_wr_en && bus.in_last;
    assign w_wr_pt      = '{x: bus.in_x, y: bus.in_y};

    // Real/filler is sampled live at idx0, then held in r_real for idx1..6 and WAIT
    assign w_at_idx0    = (r_state == PLAY) && (r_idx == '0);
    assign w_real       = w_at_idx0 ? w_rd_full : r_real;
    assign w_release    = (r_state == PLAY) && (r_idx == LAST_IDX) && r_real;

    assign bus.X        = ((r_state == PLAY) && w_real) ? w_rd_pt.x : '0;
    assign bus.Y        = ((r_state == PLAY) && w_real) ? w_rd_pt.y : '0;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_inside = r_res_inside;
    assign bus.res_id     = r_res_id;
    assign bus.frame_err  = r_frame_err;

    geofence_frame_buf #(
        .ID_W (ID_W)
    ) u_buf (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_wr_en      (w_wr_en),
        .i_wr_idx     (r_wr_idx),
        .i_wr_pt      (w_wr_pt),
        .i_commit     (w_commit),
        .i_commit_tag (r_tag_cnt),
        .i_release    (w_release),
        .i_rd_idx     (r_idx),
        .o_wr_full    (w_wr_full),
        .o_rd_full    (w_rd_full),
        .o_rd_pt      (w_rd_pt),
        .o_rd_tag     (w_rd_tag)
    );

    // Framing: point index within the frame, running tag, one-cycle error pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (reset_n == RST_ACTIVE) begin
            r_wr_idx    <= '0;
            r_tag_cnt   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_bad;
            if (w_bad || w_commit) begin
                r_wr_idx <= '0;
            end else if (w_wr_en) begin
                r_wr_idx <= r_wr_idx + IDX_W'(1);
            end
            if (w_commit) begin
                r_tag_cnt <= r_tag_cnt + ID_W'(1);
            end
        end
    end

`ifdef GEOFENCE_FEEDER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_fence_err;

    assign bus.fence_err = r_fence_err;

    // Playout FSM with watchdog: a missing verdict forces a fresh idx0 and sets the sticky error
    always_ff @(posedge clk or negedge reset_n) begin
        if (reset_n == RST_ACTIVE) begin
            r_state      <= PLAY;
            r_idx        <= '0;
            r_real       <= 1'b0;
            r_cur_tag    <= '0;
            r_res_valid  <= 1'b0;
            r_res_inside <= 1'b0;
            r_res_id     <= '0;
            r_wd_cnt     <= '0;
            r_fence_err  <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                PLAY: begin
                    if (w_at_idx0) begin
                        r_real    <= w_rd_full;
                        r_cur_tag <= w_rd_tag;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state  <= WAIT;
                        r_idx    <= '0;
                        r_wd_cnt <= '0;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                WAIT: begin
                    if (bus.fence_valid) begin
                        r_state <= PLAY;
                        if (r_real) begin
                            r_res_valid  <= 1'b1;
                            r_res_inside <= bus.fence_inside;
                            r_res_id     <= r_cur_tag;
                        end
                    end else if (r_wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        r_state     <= PLAY;
                        r_fence_err <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WD_W'(1);
                    end
                end
                default: r_state <= PLAY;
            endcase
        end
    end
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT;
    assign bus.fence_err    = 1'b0;

    // Playout FSM: seven output cycles, then wait as long as it takes for the engine verdict
    always_ff @(posedge clk or negedge reset_n) begin
        if (reset_n == RST_ACTIVE) begin
            r_state      <= PLAY;
            r_idx        <= '0;
            r_real       <= 1'b0;
            r_cur_tag    <= '0;
            r_res_valid  <= 1'b0;
            r_res_inside <= 1'b0;
            r_res_id     <= '0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                PLAY: begin
                    if (w_at_idx0) begin
                        r_real    <= w_rd_full;
                        r_cur_tag <= w_rd_tag;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= WAIT;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                WAIT: begin
                    if (bus.fence_valid) begin
                        r_state <= PLAY;
                        if (r_real) begin
                            r_res_valid  <= 1'b1;
                            r_res_inside <= bus.fence_inside;
                            r_res_id     <= r_cur_tag;
                        end
                    end
                end
                default: r_state <= PLAY;
            endcase
        end
    end
`endif

endmodule
